pc_sequencer: RTL and testbench

- Controller for the 16-bit PC register. Each cycle it computes the next fetch address and drives the PC register's 2-bit nop control.
- Also drives stall and flush controls for the IF/ID and ID/EX pipeline registers.
- Arbitrates four PC update sources: sequential increment, taken branch, load-use stall, and instruction-memory wait.
- Supports a halt/resume handshake for the debug path.

---
 rtl/pc_seq_pkg.sv | 33 +++
 rtl/pc_seq_counter.sv | 45 ++++
 rtl/pc_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC sequencer slice.
//   seq_state_t   - sequencer FSM state encoding (also exported as seq_state)
//   PC_NOP_*      - nop codes understood by the PC register
//   CNT_W         - width of the shared STALL/FLUSH down-counter
//   PERF_W        - width of the optional performance counters
//   sat_inc()     - saturating increment used by the performance counters
package pc_seq_pkg;

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    RUN      = 3'd1,
    STALL    = 3'd2,
    WAIT_MEM = 3'd3,
    FLUSH    = 3'd4,
    HALT     = 3'd5
  } seq_state_t;

  localparam logic [1:0] PC_NOP_UPDATE = 2'b00;
  localparam logic [1:0] PC_NOP_HOLD   = 2'b01;

  localparam int CNT_W  = 3;
  localparam int PERF_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    if (v == {PERF_W{1'b1}}) begin
      return v;
    end else begin
      return v + PERF_W'(1);
    end
  endfunction

endpackage

// File: rtl/pc_seq_counter.sv
// pc_seq_counter: loadable down-counter shared by the STALL and FLUSH states.
//   clk, reset - clock, synchronous active-high reset (count clears to 0)
//   load       - load load_val this cycle (wins over dec)
//   load_val   - value to load
//   dec        - decrement this cycle (holds at 0)
//   zero       - the count is zero once this cycle's decrement is applied,
//                i.e. the current cycle is the last one of the hold window
module pc_seq_counter
  import pc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q <= CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-fetch-address and pipeline-control sequencer for the PC.
// Arbitrates halt, taken branch, load-use stall and instruction-memory wait,
// and drives the PC register input/nop plus IF/ID and ID/EX stall/flush.
//   Inputs : clk, reset (sync, active-high), pc_current, branch_taken,
//            branch_target, load_use_hazard, imem_ready, halt_req, resume
//   Outputs: pc_next, pc_nop (00 update / 01 hold), stall_if_id, flush_if_id,
//            flush_id_ex, halted, seq_state (debug)
// Optional: define PC_SEQ_PERF_CNT_EN to add saturating 16-bit stall_count,
//           flush_count and wait_count outputs.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 16,
  parameter int unsigned        PC_STEP      = 1,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = 16'h0000,
  parameter int unsigned        STALL_CYCLES = 1,
  parameter int unsigned        FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_current,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              load_use_hazard,
  input  logic              imem_ready,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_next,
  output logic [1:0]        pc_nop,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              halted,
  output logic [2:0]        seq_state
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count,
  output logic [PERF_W-1:0] wait_count
`endif
);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              stall_evt;
  logic              flush_evt;
  logic              wait_evt;

  assign pc_inc = pc_current + ADDR_W'(PC_STEP);

  pc_seq_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state and output decode; reset forces the BOOT outputs regardless of state.
  always_comb begin
    state_d      = state_q;
    pc_next      = pc_current;
    pc_nop       = PC_NOP_HOLD;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    halted       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = {CNT_W{1'b0}};
    cnt_dec      = 1'b0;
    stall_evt    = 1'b0;
    flush_evt    = 1'b0;
    wait_evt     = 1'b0;
    if (reset) begin
      state_d     = BOOT;
      pc_next     = RESET_VECTOR;
      pc_nop      = PC_NOP_UPDATE;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      case (state_q)
        BOOT: begin
          state_d     = RUN;
          pc_next     = RESET_VECTOR;
          pc_nop      = PC_NOP_UPDATE;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
        HALT: begin
          // PC stays frozen in the resume cycle; the first increment happens in RUN.
          stall_if_id = 1'b1;
          halted      = 1'b1;
          if (resume && !halt_req) begin
            state_d = RUN;
          end else begin
            state_d = HALT;
          end
        end
        RUN, STALL, WAIT_MEM, FLUSH: begin
          if ((state_q == RUN) && halt_req) begin
            // Hold the PC in the request cycle so the frozen value is the current one.
            state_d     = HALT;
            stall_if_id = 1'b1;
          end else if (branch_taken) begin
            // A resolved branch preempts every hold state and restarts the flush window.
            pc_next     = branch_target;
            pc_nop      = PC_NOP_UPDATE;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            flush_evt   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d      = FLUSH;
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(FLUSH_CYCLES - 1);
            end else begin
              state_d = RUN;
            end
          end else begin
            case (state_q)
              RUN: begin
                if (load_use_hazard) begin
                  stall_if_id = 1'b1;
                  flush_id_ex = 1'b1;
                  stall_evt   = 1'b1;
                  if (STALL_CYCLES > 1) begin
                    state_d      = STALL;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(STALL_CYCLES - 1);
                  end else begin
                    state_d = RUN;
                  end
                end else if (!imem_ready) begin
                  stall_if_id = 1'b1;
                  flush_id_ex = 1'b1;
                  state_d     = WAIT_MEM;
                end else begin
                  pc_next = pc_inc;
                  pc_nop  = PC_NOP_UPDATE;
                  state_d = RUN;
                end
              end
              STALL: begin
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
                cnt_dec     = 1'b1;
                stall_evt   = 1'b1;
                if (cnt_zero) begin
                  state_d = RUN;
                end else begin
                  state_d = STALL;
                end
              end
              WAIT_MEM: begin
                wait_evt = 1'b1;
                if (imem_ready) begin
                  pc_next = pc_inc;
                  pc_nop  = PC_NOP_UPDATE;
                  state_d = RUN;
                end else begin
                  stall_if_id = 1'b1;
                  flush_id_ex = 1'b1;
                  state_d     = WAIT_MEM;
                end
              end
              FLUSH: begin
                pc_next     = pc_inc;
                pc_nop      = PC_NOP_UPDATE;
                flush_if_id = 1'b1;
                cnt_dec     = 1'b1;
                flush_evt   = 1'b1;
                if (cnt_zero) begin
                  state_d = RUN;
                end else begin
                  state_d = FLUSH;
                end
              end
              default: begin
                state_d = BOOT;
              end
            endcase
          end
        end
        default: begin
          // Unreachable encodings recover through BOOT.
          state_d     = BOOT;
          pc_next     = RESET_VECTOR;
          pc_nop      = PC_NOP_UPDATE;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  assign seq_state = reset ? BOOT : state_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q;
  logic [PERF_W-1:0] flush_cnt_d;
  logic [PERF_W-1:0] wait_cnt_q;
  logic [PERF_W-1:0] wait_cnt_d;

  // Saturating event counters, one step per qualifying cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (stall_evt) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_evt) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (wait_evt) begin
      wait_cnt_d = sat_inc(wait_cnt_q);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= {PERF_W{1'b0}};
      flush_cnt_q <= {PERF_W{1'b0}};
      wait_cnt_q  <= {PERF_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign wait_count  = wait_cnt_q;
`else
  logic unused_perf_evt;
  assign unused_perf_evt = ^{stall_evt, flush_evt, wait_evt};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed, table-driven bench for pc_sequencer
// (STALL_CYCLES=2, FLUSH_CYCLES=2). Each record gives one cycle of inputs
// (including the PC register value) and the expected combinational outputs.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] pc_current;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        load_use_hazard;
  logic        imem_ready;
  logic        halt_req;
  logic        resume;
  logic [15:0] pc_next;
  logic [1:0]  pc_nop;
  logic        stall_if_id;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halted;
  logic [2:0]  seq_state;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic [15:0] wait_count;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .ADDR_W       (16),
    .PC_STEP      (1),
    .RESET_VECTOR (16'h0000),
    .STALL_CYCLES (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_current      (pc_current),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .load_use_hazard (load_use_hazard),
    .imem_ready      (imem_ready),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_next         (pc_next),
    .pc_nop          (pc_nop),
    .stall_if_id     (stall_if_id),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .halted          (halted),
    .seq_state       (seq_state)
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .wait_count      (wait_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        br;
    logic [15:0] tgt;
    logic        luh;
    logic        rdy;
    logic        hreq;
    logic        res;
    logic [15:0] e_next;
    logic [1:0]  e_nop;
    logic        e_st;
    logic        e_fi;
    logic        e_fe;
    logic        e_h;
    logic [2:0]  e_s;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [15:0] pc, input logic br,
                              input logic [15:0] tgt, input logic luh, input logic rdy,
                              input logic hreq, input logic res, input logic [15:0] e_next,
                              input logic [1:0] e_nop, input logic e_st, input logic e_fi,
                              input logic e_fe, input logic e_h, input logic [2:0] e_s);
    vec_t v;
    v.rst = rst; v.pc = pc; v.br = br; v.tgt = tgt; v.luh = luh; v.rdy = rdy;
    v.hreq = hreq; v.res = res; v.e_next = e_next; v.e_nop = e_nop; v.e_st = e_st;
    v.e_fi = e_fi; v.e_fe = e_fe; v.e_h = e_h; v.e_s = e_s;
    return v;
  endfunction

  // Drive one cycle of inputs, compare on the falling edge, then advance past the rising edge.
  task automatic run_vec(input vec_t v, input string name);
    logic [24:0] got;
    logic [24:0] want;
    reset = v.rst; pc_current = v.pc; branch_taken = v.br; branch_target = v.tgt;
    load_use_hazard = v.luh; imem_ready = v.rdy; halt_req = v.hreq; resume = v.res;
    @(negedge clk);
    got  = {pc_next, pc_nop, stall_if_id, flush_if_id, flush_id_ex, halted, seq_state};
    want = {v.e_next, v.e_nop, v.e_st, v.e_fi, v.e_fe, v.e_h, v.e_s};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got next=%h nop=%b st=%b fi=%b fe=%b h=%b s=%0d, want next=%h nop=%b st=%b fi=%b fe=%b h=%b s=%0d",
               name, pc_next, pc_nop, stall_if_id, flush_if_id, flush_id_ex, halted, seq_state,
               v.e_next, v.e_nop, v.e_st, v.e_fi, v.e_fe, v.e_h, v.e_s);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    reset = 1'b1; pc_current = 16'h1234; branch_taken = 1'b0; branch_target = 16'h0000;
    load_use_hazard = 1'b0; imem_ready = 1'b1; halt_req = 1'b0; resume = 1'b0;

    //                rst   pc        br    tgt       luh   rdy   hreq  res   next      nop    st    fi    fe    h     s
    // reset held three cycles overrides all inputs
    tbl.push_back(mk(1'b1, 16'h1234, 1'b1, 16'h0777, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    // BOOT then sequential fetch
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // taken branch at 0010 -> 0040, one FLUSH cycle
    tbl.push_back(mk(1'b0, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0041, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, 16'h0041, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0042, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0043, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // load-use at 0020: two hold cycles
    tbl.push_back(mk(1'b0, 16'h0020, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0020, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2));
    tbl.push_back(mk(1'b0, 16'h0020, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0021, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // imem wait at 0030, branch to 0100 on the third low cycle
    tbl.push_back(mk(1'b0, 16'h0030, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0030, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3));
    tbl.push_back(mk(1'b0, 16'h0030, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3));
    tbl.push_back(mk(1'b0, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, 16'h0101, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0102, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // imem wait resolved by imem_ready
    tbl.push_back(mk(1'b0, 16'h0102, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0102, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0102, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0103, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
    tbl.push_back(mk(1'b0, 16'h0103, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0104, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // wrap FFFF -> 0000
    tbl.push_back(mk(1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // branch outranks load-use and imem wait
    tbl.push_back(mk(1'b0, 16'h0200, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0300, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0301, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, 16'h0301, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0302, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // halt at 0050 for five HALT cycles, resume with halt_req held is ignored
    tbl.push_back(mk(1'b0, 16'h0050, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0050, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0050, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, 16'h0050, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, 16'h0050, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, 16'h0050, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0050, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, 16'h0050, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0050, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, 16'h0050, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0051, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // halt outranks branch in RUN; branch ignored in HALT
    tbl.push_back(mk(1'b0, 16'h0051, 1'b1, 16'h0700, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0051, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0051, 1'b1, 16'h0700, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0051, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, 16'h0051, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0051, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, 16'h0051, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0052, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // branch preempts STALL
    tbl.push_back(mk(1'b0, 16'h0060, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0060, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, 16'h0060, 1'b1, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0080, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2));
    tbl.push_back(mk(1'b0, 16'h0080, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0081, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, 16'h0081, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0082, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Branch during FLUSH reloads the counter: FLUSH lasts one more cycle after the redirect.
    seq.delete();
    seq.push_back(mk(1'b0, 16'h0082, 1'b1, 16'h0400, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0400, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1));
    seq.push_back(mk(1'b0, 16'h0400, 1'b1, 16'h0500, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0500, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4));
    seq.push_back(mk(1'b0, 16'h0500, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0501, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4));
    seq.push_back(mk(1'b0, 16'h0501, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0502, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    for (int i = 0; i < seq.size(); i++) begin
      run_vec(seq[i], $sformatf("flush_reload%0d", i));
    end

    // Reset asserted in HALT returns to BOOT with halted low.
    seq.delete();
    seq.push_back(mk(1'b0, 16'h0502, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0502, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
    seq.push_back(mk(1'b0, 16'h0502, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0502, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5));
    seq.push_back(mk(1'b1, 16'h0502, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    seq.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    seq.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    for (int i = 0; i < seq.size(); i++) begin
      run_vec(seq[i], $sformatf("halt_reset%0d", i));
    end

    // Load-use outranks imem wait; the wait is then served after the stall.
    seq.delete();
    seq.push_back(mk(1'b0, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1));
    seq.push_back(mk(1'b0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2));
    seq.push_back(mk(1'b0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1));
    seq.push_back(mk(1'b0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
    seq.push_back(mk(1'b0, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    for (int i = 0; i < seq.size(); i++) begin
      run_vec(seq[i], $sformatf("luh_wait%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
